// File: rtl/quadrature_pkg.sv
// Shared definitions for the quadrature decoder family: phase encodings,
// transition classes and the detent-size legality check.
package quadrature_pkg;

  localparam logic [1:0] PH_00 = 2'b00;
  localparam logic [1:0] PH_10 = 2'b10;
  localparam logic [1:0] PH_11 = 2'b11;
  localparam logic [1:0] PH_01 = 2'b01;

  typedef enum logic [1:0] {
    TR_NONE,
    TR_INC,
    TR_DEC,
    TR_ILLEGAL
  } transition_t;

  // Next phase in the clockwise Gray sequence 00 -> 10 -> 11 -> 01 -> 00.
  function automatic logic [1:0] cw_successor(input logic [1:0] ph);
    case (ph)
      PH_00:   cw_successor = PH_10;
      PH_10:   cw_successor = PH_11;
      PH_11:   cw_successor = PH_01;
      default: cw_successor = PH_00;
    endcase
  endfunction

  function automatic bit steps_legal(input int steps);
    return (steps == 1) || (steps == 2) || (steps == 4);
  endfunction

endpackage

// File: rtl/quadrature_phase_classifier.sv
// Pure combinational classifier of a (previous, current) phase pair into
// one of NONE / INC / DEC / ILLEGAL.
module quadrature_phase_classifier
  import quadrature_pkg::*;
(
  input  logic [1:0]  i_phase_prev,
  input  logic [1:0]  i_phase_now,
  output transition_t o_transition
);

  always_comb begin
    o_transition = TR_NONE;
    if ((i_phase_prev ^ i_phase_now) == 2'b11) begin
      o_transition = TR_ILLEGAL;
    end else if (i_phase_now == cw_successor(i_phase_prev)) begin
      o_transition = TR_INC;
    end else if (i_phase_prev == cw_successor(i_phase_now)) begin
      o_transition = TR_DEC;
    end
  end

endmodule

// File: rtl/quadrature_step_decoder.sv
// 4x quadrature decoder with a signed sub-step accumulator; emits one
// registered pulse per mechanical detent and flags double-phase jumps.
module quadrature_step_decoder
  import quadrature_pkg::*;
#(
  parameter int STEPS_PER_DETENT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic A,
  input  logic B,
  output logic Clockwise,
  output logic counterClockwise,
  output logic illegalTransition
);

  localparam int SUB_W = $clog2(STEPS_PER_DETENT) + 2;
  localparam logic signed [SUB_W-1:0] SUB_ONE  = SUB_W'(1);
  localparam logic signed [SUB_W-1:0] STEP_MAX = SUB_W'(STEPS_PER_DETENT);
  localparam logic signed [SUB_W-1:0] STEP_MIN = -STEP_MAX;

  if (!steps_legal(STEPS_PER_DETENT)) begin : g_bad_steps
    $error("quadrature_step_decoder: STEPS_PER_DETENT must be 1, 2 or 4");
  end

  logic [1:0]              r_phase_p0;
  logic [1:0]              r_phase_p1;
  logic signed [SUB_W-1:0] r_sub_step;
  logic                    r_cw;
  logic                    r_ccw;
  logic                    r_illegal;
  transition_t             w_transition;
  logic signed [SUB_W-1:0] w_sub_inc;
  logic signed [SUB_W-1:0] w_sub_dec;

  quadrature_phase_classifier u_classifier (
    .i_phase_prev (r_phase_p1),
    .i_phase_now  (r_phase_p0),
    .o_transition (w_transition)
  );

  assign w_sub_inc = r_sub_step + SUB_ONE;
  assign w_sub_dec = r_sub_step - SUB_ONE;

  // Stage p0/p1: phase history; stage p2: classification into accumulator and pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      // Preload both phase registers so a non-00 rest position is not a step.
      r_phase_p0 <= {A, B};
      r_phase_p1 <= {A, B};
      r_sub_step <= '0;
      r_cw       <= 1'b0;
      r_ccw      <= 1'b0;
      r_illegal  <= 1'b0;
    end else begin
      r_phase_p0 <= {A, B};
      r_phase_p1 <= r_phase_p0;
      r_cw       <= 1'b0;
      r_ccw      <= 1'b0;
      r_illegal  <= 1'b0;
      case (w_transition)
        TR_ILLEGAL: begin
          r_illegal  <= 1'b1;
          r_sub_step <= '0;
        end
        TR_INC: begin
          if (enable) begin
            if (w_sub_inc == STEP_MAX) begin
              r_cw       <= 1'b1;
              r_sub_step <= '0;
            end else begin
              r_sub_step <= w_sub_inc;
            end
          end
        end
        TR_DEC: begin
          if (enable) begin
            if (w_sub_dec == STEP_MIN) begin
              r_ccw      <= 1'b1;
              r_sub_step <= '0;
            end else begin
              r_sub_step <= w_sub_dec;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign Clockwise         = r_cw;
  assign counterClockwise  = r_ccw;
  assign illegalTransition = r_illegal;

endmodule

// File: tb/tb_quadrature_step_decoder.sv
// Directed bench for quadrature_step_decoder with a 4-step and a 1-step instance.
module tb_quadrature_step_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst4, en4, a4, b4;
  logic cw4, ccw4, ill4;
  logic rst1, en1, a1, b1;
  logic cw1, ccw1, ill1;

  quadrature_step_decoder #(.STEPS_PER_DETENT(4)) dut4 (
    .clk               (clk),
    .reset             (rst4),
    .enable            (en4),
    .A                 (a4),
    .B                 (b4),
    .Clockwise         (cw4),
    .counterClockwise  (ccw4),
    .illegalTransition (ill4)
  );

  quadrature_step_decoder #(.STEPS_PER_DETENT(1)) dut1 (
    .clk               (clk),
    .reset             (rst1),
    .enable            (en1),
    .A                 (a1),
    .B                 (b1),
    .Clockwise         (cw1),
    .counterClockwise  (ccw1),
    .illegalTransition (ill1)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cw4_cnt = 0, ccw4_cnt = 0, ill4_cnt = 0, ovl4_cnt = 0;

  task automatic cyc4(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
      if (cw4 === 1'b1) cw4_cnt++;
      if (ccw4 === 1'b1) ccw4_cnt++;
      if (ill4 === 1'b1) ill4_cnt++;
      if ($countones({cw4, ccw4, ill4}) > 1) ovl4_cnt++;
    end
  endtask

  task automatic clr4();
    cw4_cnt = 0; ccw4_cnt = 0; ill4_cnt = 0;
  endtask

  task automatic ph4(input logic [1:0] p, input int n);
    {a4, b4} = p;
    cyc4(n);
  endtask

  task automatic reset4(input logic [1:0] p);
    {a4, b4} = p;
    rst4 = 1'b1;
    cyc4(2);
    rst4 = 1'b0;
    clr4();
  endtask

  task automatic test_reset();
    en4 = 1'b1;
    {a4, b4} = 2'b11;
    rst4 = 1'b1;
    cyc4(3);
    n_cmp++;
    if ({cw4, ccw4, ill4} !== 3'b000) begin
      n_err++; $display("FAIL reset_outputs: got %b expected 000", {cw4, ccw4, ill4});
    end
    n_cmp++;
    if (dut4.r_sub_step !== 4'sd0) begin
      n_err++; $display("FAIL reset_substep: got %0d expected 0", dut4.r_sub_step);
    end
    rst4 = 1'b0;
    clr4();
    ph4(2'b11, 20);
    n_cmp++;
    if (cw4_cnt !== 0 || ccw4_cnt !== 0 || ill4_cnt !== 0) begin
      n_err++; $display("FAIL rest_11_no_pulse: got cw=%0d ccw=%0d ill=%0d expected 0 0 0",
                        cw4_cnt, ccw4_cnt, ill4_cnt);
    end
  endtask

  task automatic test_cw_detent();
    reset4(2'b00);
    ph4(2'b10, 5);
    ph4(2'b11, 5);
    ph4(2'b01, 5);
    n_cmp++;
    if (cw4_cnt !== 0) begin
      n_err++; $display("FAIL cw_no_early_pulse: got %0d expected 0", cw4_cnt);
    end
    n_cmp++;
    if (dut4.r_sub_step !== 4'sd3) begin
      n_err++; $display("FAIL cw_substep3: got %0d expected 3", dut4.r_sub_step);
    end
    {a4, b4} = 2'b00;
    cyc4(1);
    n_cmp++;
    if (cw4 !== 1'b0) begin
      n_err++; $display("FAIL cw_latency_edge1: got %b expected 0", cw4);
    end
    cyc4(1);
    n_cmp++;
    if (cw4 !== 1'b1) begin
      n_err++; $display("FAIL cw_latency_edge2: got %b expected 1", cw4);
    end
    cyc4(1);
    n_cmp++;
    if (cw4 !== 1'b0) begin
      n_err++; $display("FAIL cw_width: got %b expected 0", cw4);
    end
    cyc4(3);
    n_cmp++;
    if (cw4_cnt !== 1 || ccw4_cnt !== 0) begin
      n_err++; $display("FAIL cw_detent_count: got cw=%0d ccw=%0d expected 1 0", cw4_cnt, ccw4_cnt);
    end
  endtask

  task automatic test_jitter_reverse();
    clr4();
    ph4(2'b10, 5); ph4(2'b00, 5); ph4(2'b10, 5); ph4(2'b00, 5);
    n_cmp++;
    if (cw4_cnt !== 0 || ccw4_cnt !== 0 || ill4_cnt !== 0) begin
      n_err++; $display("FAIL jitter_no_pulse: got cw=%0d ccw=%0d ill=%0d expected 0 0 0",
                        cw4_cnt, ccw4_cnt, ill4_cnt);
    end
    n_cmp++;
    if (dut4.r_sub_step !== 4'sd0) begin
      n_err++; $display("FAIL jitter_substep: got %0d expected 0", dut4.r_sub_step);
    end
    clr4();
    for (int r = 0; r < 2; r++) begin
      ph4(2'b01, 5); ph4(2'b11, 5); ph4(2'b10, 5); ph4(2'b00, 5);
    end
    n_cmp++;
    if (ccw4_cnt !== 2 || cw4_cnt !== 0 || ill4_cnt !== 0) begin
      n_err++; $display("FAIL ccw_two_detents: got ccw=%0d cw=%0d ill=%0d expected 2 0 0",
                        ccw4_cnt, cw4_cnt, ill4_cnt);
    end
  endtask

  task automatic test_illegal();
    clr4();
    ph4(2'b11, 5);
    n_cmp++;
    if (ill4_cnt !== 1 || cw4_cnt !== 0 || ccw4_cnt !== 0) begin
      n_err++; $display("FAIL illegal_00_11: got ill=%0d cw=%0d ccw=%0d expected 1 0 0",
                        ill4_cnt, cw4_cnt, ccw4_cnt);
    end
    ph4(2'b01, 5); ph4(2'b00, 5); ph4(2'b10, 5); ph4(2'b11, 5);
    n_cmp++;
    if (cw4_cnt !== 1) begin
      n_err++; $display("FAIL cw_after_illegal: got %0d expected 1", cw4_cnt);
    end
    clr4();
    ph4(2'b01, 5);
    ph4(2'b10, 5);
    n_cmp++;
    if (ill4_cnt !== 1 || dut4.r_sub_step !== 4'sd0) begin
      n_err++; $display("FAIL illegal_clears_substep: got ill=%0d sub=%0d expected 1 0",
                        ill4_cnt, dut4.r_sub_step);
    end
    ph4(2'b11, 5); ph4(2'b01, 5); ph4(2'b00, 5);
    n_cmp++;
    if (cw4_cnt !== 0) begin
      n_err++; $display("FAIL illegal_partial_discarded: got %0d expected 0", cw4_cnt);
    end
    ph4(2'b10, 5);
    n_cmp++;
    if (cw4_cnt !== 1) begin
      n_err++; $display("FAIL illegal_full_cycle: got %0d expected 1", cw4_cnt);
    end
  endtask

  task automatic test_enable();
    clr4();
    en4 = 1'b0;
    ph4(2'b11, 5); ph4(2'b01, 5); ph4(2'b00, 5); ph4(2'b10, 5);
    n_cmp++;
    if (cw4_cnt !== 0 || ccw4_cnt !== 0 || dut4.r_sub_step !== 4'sd0) begin
      n_err++; $display("FAIL disabled_no_count: got cw=%0d ccw=%0d sub=%0d expected 0 0 0",
                        cw4_cnt, ccw4_cnt, dut4.r_sub_step);
    end
    en4 = 1'b1;
    ph4(2'b11, 5); ph4(2'b01, 5); ph4(2'b00, 5); ph4(2'b10, 5);
    n_cmp++;
    if (cw4_cnt !== 1) begin
      n_err++; $display("FAIL reenabled_one_pulse: got %0d expected 1", cw4_cnt);
    end
    clr4();
    ph4(2'b11, 5); ph4(2'b01, 5); ph4(2'b00, 5);
    en4 = 1'b0;
    ph4(2'b10, 5);
    n_cmp++;
    if (cw4_cnt !== 0 || dut4.r_sub_step !== 4'sd3) begin
      n_err++; $display("FAIL disable_on_completion: got cw=%0d sub=%0d expected 0 3",
                        cw4_cnt, dut4.r_sub_step);
    end
    en4 = 1'b1;
    ph4(2'b11, 5);
    n_cmp++;
    if (cw4_cnt !== 1 || dut4.r_sub_step !== 4'sd0) begin
      n_err++; $display("FAIL held_substep_completes: got cw=%0d sub=%0d expected 1 0",
                        cw4_cnt, dut4.r_sub_step);
    end
    clr4();
    en4 = 1'b0;
    ph4(2'b00, 5);
    n_cmp++;
    if (ill4_cnt !== 1) begin
      n_err++; $display("FAIL illegal_while_disabled: got %0d expected 1", ill4_cnt);
    end
    en4 = 1'b1;
  endtask

  task automatic test_reset_mid_detent();
    clr4();
    ph4(2'b10, 5); ph4(2'b11, 5);
    reset4(2'b11);
    ph4(2'b01, 5); ph4(2'b00, 5);
    n_cmp++;
    if (cw4_cnt !== 0 || dut4.r_sub_step !== 4'sd2) begin
      n_err++; $display("FAIL reset_discards_partial: got cw=%0d sub=%0d expected 0 2",
                        cw4_cnt, dut4.r_sub_step);
    end
    ph4(2'b10, 5); ph4(2'b11, 5);
    n_cmp++;
    if (cw4_cnt !== 1) begin
      n_err++; $display("FAIL post_reset_full_detent: got %0d expected 1", cw4_cnt);
    end
    n_cmp++;
    if (ovl4_cnt !== 0) begin
      n_err++; $display("FAIL outputs_exclusive: got %0d overlap cycles expected 0", ovl4_cnt);
    end
  endtask

  task automatic test_steps1_back_to_back();
    logic [1:0]  pat [4];
    logic [10:0] seq;
    int          others;
    pat = '{2'b10, 2'b11, 2'b01, 2'b00};
    seq = '0;
    others = 0;
    en1 = 1'b1;
    {a1, b1} = 2'b00;
    rst1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst1 = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < 11; c++) begin
      if (c < 8) {a1, b1} = pat[c % 4];
      @(posedge clk);
      #1;
      seq[c] = cw1;
      if (ccw1 !== 1'b0 || ill1 !== 1'b0) others++;
    end
    n_cmp++;
    if (seq !== 11'b00111111110) begin
      n_err++; $display("FAIL steps1_eight_pulses: got %b expected 00111111110", seq);
    end
    n_cmp++;
    if (others !== 0) begin
      n_err++; $display("FAIL steps1_no_other_pulse: got %0d expected 0", others);
    end
  endtask

  task automatic test_steps1_reset();
    logic [1:0]  pat [4];
    logic [12:0] seq;
    pat = '{2'b10, 2'b11, 2'b01, 2'b00};
    seq = '0;
    for (int c = 0; c < 13; c++) begin
      rst1 = (c == 5);
      if (c < 10) {a1, b1} = pat[c % 4];
      @(posedge clk);
      #1;
      seq[c] = cw1;
    end
    rst1 = 1'b0;
    n_cmp++;
    if (seq !== 13'b0011110011110) begin
      n_err++; $display("FAIL steps1_reset_on_5th: got %b expected 0011110011110", seq);
    end
  endtask

  initial begin
    rst4 = 1'b1; en4 = 1'b1; a4 = 1'b0; b4 = 1'b0;
    rst1 = 1'b1; en1 = 1'b1; a1 = 1'b0; b1 = 1'b0;
    test_reset();
    test_cw_detent();
    test_jitter_reverse();
    test_illegal();
    test_enable();
    test_reset_mid_detent();
    test_steps1_back_to_back();
    test_steps1_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/quadrature_step_decoder.md
# quadrature_step_decoder

Converts the two debounced, active-high rotary-encoder phase signals into single-cycle clockwise / counter-clockwise detent pulses that drive the signed position counter and display path. Sits between the per-phase latch debouncers and the position counter. Uses full 4x quadrature decoding with a sub-step accumulator, so one pulse is issued per mechanical detent. Illegal double-phase jumps are flagged instead of miscounted.

## Interface
- STEPS_PER_DETENT, 4: quadrature edges per output pulse; legal values 1, 2, 4.
- clk  input  1  system clock; all logic on posedge clk.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  high: counting enabled; low: phase tracked, no counting, no pulses.
- A  input  1  debounced phase A, active high.
- B  input  1  debounced phase B, active high.
- Clockwise  output  1  one-cycle pulse per clockwise detent.
- counterClockwise  output  1  one-cycle pulse per counter-clockwise detent.
- illegalTransition  output  1  one-cycle pulse when both phases change in the same sample.

## Operation
- Phase = {A,B}. Clockwise Gray order: 00 → 10 → 11 → 01 → 00 (A leads B). Reverse order is counter-clockwise.
- Registers:
  - phaseNow <= {A,B} every cycle.
  - phasePrev <= phaseNow.
- Each cycle (phasePrev, phaseNow) is classified as exactly one of:
  - NONE: equal.
  - INC: one clockwise Gray step.
  - DEC: one counter-clockwise Gray step.
  - ILLEGAL: both bits differ.
- subStep accumulator: signed, width $clog2(STEPS_PER_DETENT)+2, range −STEPS_PER_DETENT..+STEPS_PER_DETENT, reset 0.
- INC with enable high:
  - If subStep+1 == STEPS_PER_DETENT: Clockwise <= 1 and subStep <= 0.
  - Otherwise subStep <= subStep+1.
- DEC with enable high: mirror of INC; at −STEPS_PER_DETENT, counterClockwise <= 1 and subStep <= 0.
- Direction reversal mid-detent is handled by the same rule: the accumulator walks back toward 0 with no pulse, so jitter about one edge never produces a pulse.
- ILLEGAL (regardless of enable): illegalTransition <= 1, subStep <= 0, no direction pulse. The phase registers still take the new value.
- enable low: subStep holds, Clockwise and counterClockwise forced 0, ILLEGAL still reported.
- At most one of Clockwise, counterClockwise and illegalTransition is high in any cycle.
- Reset (synchronous, takes priority over all other activity):
  - phaseNow and phasePrev load the current {A,B}, so a non-00 resting position produces no spurious step.
  - subStep <= 0.
  - All three outputs <= 0.

## Timing
- Outputs are registered; reset value of every output is 0.
- Latency: {A,B} changes before edge k; phaseNow updates at edge k; the classification is registered at edge k+1. The pulse is therefore high for exactly the cycle between edges k+1 and k+2.
- A new phase value may arrive every cycle. Each transition is counted exactly once, with no dead cycles.
- Reset asserted mid-detent discards the partial subStep. The first post-reset pulse needs a full STEPS_PER_DETENT edges.
- Reset and a completing transition in the same cycle: reset wins; no pulse.
- Deasserting enable during a completing transition: no pulse; subStep holds its pre-transition value.

## Structure
- Shared package quadrature_pkg holds:
  - Phase constants PH_00, PH_10, PH_11, PH_01.
  - Enumerated transition type {TR_NONE, TR_INC, TR_DEC, TR_ILLEGAL}.
  - The STEPS_PER_DETENT legality check, as an elaboration-time assertion.
- One combinational sub-module, quadrature_phase_classifier: (phasePrev, phaseNow) → transition type. It is reusable by a future velocity estimator.
- Top contains the phase registers, the accumulator, and the output registers.

## Test plan
- Reset with {A,B}=11, release, hold 20 cycles → all outputs 0, no pulse.
- STEPS=4, drive 00,10,11,01,00, 5 cycles per phase → exactly one Clockwise pulse, 1 cycle wide, 2 edges after the final 00 is applied; counterClockwise stays 0.
- Drive 00,10,00,10,00 (edge jitter) → no pulses; subStep returns to 0. Then two full reverse cycles 00,01,11,10,00 ×2 → exactly two counterClockwise pulses.
- Jump 00→11 directly → one illegalTransition pulse, subStep 0. A following full clockwise cycle starting from 11 → one Clockwise pulse after 4 edges.
- enable=0 during one full clockwise cycle → no pulses. enable=1 plus one further cycle → exactly one pulse.
- STEPS=1, phase changes every cycle for 8 clockwise edges → 8 consecutive Clockwise pulses. Reset asserted on the 5th edge → only 4 pulses, then resumes cleanly.
